// File: rtl/open_list_expander_if.sv
// Handshake bundle between the A* open-list expander and its neighbours:
// popped-node input, occupancy-map lookup and open-list write port.
interface open_list_expander_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MAP_WIDTH  = 16,
    parameter int MAP_HEIGHT = 16
);
    logic                  i_start;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_node_g;
    logic [MAP_WIDTH-1:0]  i_node_i;
    logic [MAP_HEIGHT-1:0] i_node_j;
    logic [MAP_WIDTH-1:0]  i_goal_i;
    logic [MAP_HEIGHT-1:0] i_goal_j;
    logic                  o_map_rd;
    logic [MAP_WIDTH-1:0]  o_map_i;
    logic [MAP_HEIGHT-1:0] o_map_j;
    logic                  i_map_blocked;
    logic                  i_full;
    logic                  o_wrt;
    logic [DATA_WIDTH-1:0] o_node_f;
    logic [MAP_WIDTH-1:0]  o_node_i;
    logic [MAP_HEIGHT-1:0] o_node_j;
    logic                  o_done;
    logic [3:0]            o_count;

    modport slave (
        input  i_start, i_node_g, i_node_i, i_node_j, i_goal_i, i_goal_j,
        input  i_map_blocked, i_full,
        output o_ready, o_map_rd, o_map_i, o_map_j,
        output o_wrt, o_node_f, o_node_i, o_node_j, o_done, o_count
    );

    modport master (
        output i_start, i_node_g, i_node_i, i_node_j, i_goal_i, i_goal_j,
        output i_map_blocked, i_full,
        input  o_ready, o_map_rd, o_map_i, o_map_j,
        input  o_wrt, o_node_f, o_node_i, o_node_j, o_done, o_count
    );
endinterface

// File: rtl/open_list_expander.sv
// A* expansion stage: generates in-bounds, unblocked grid neighbours of a popped node and writes f=g+1+h to the open list.
// Define OPEN_LIST_EXPANDER_DIAGONAL_EN for 8-way moves with Chebyshev h; default is 4-way with Manhattan h.
module open_list_expander #(
    parameter int DATA_WIDTH = 32,
    parameter int MAP_WIDTH  = 16,
    parameter int MAP_HEIGHT = 16,
    parameter int GRID_I     = 16,
    parameter int GRID_J     = 16
) (
    input logic                 CLK,
    input logic                 RSTn,
    open_list_expander_if.slave bus
);
`ifdef OPEN_LIST_EXPANDER_DIAGONAL_EN
    localparam int NUM_DIRS = 8;
`else
    localparam int NUM_DIRS = 4;
`endif
    localparam logic [2:0]          LAST_DIR = 3'(NUM_DIRS - 1);
    localparam int                  H_W      = ((MAP_WIDTH > MAP_HEIGHT) ? MAP_WIDTH : MAP_HEIGHT) + 1;
    localparam int                  F_W      = DATA_WIDTH + 2;
    localparam logic [MAP_WIDTH:0]  I_MAX    = (MAP_WIDTH + 1)'(GRID_I - 1);
    localparam logic [MAP_HEIGHT:0] J_MAX    = (MAP_HEIGHT + 1)'(GRID_J - 1);
    localparam logic [MAP_WIDTH:0]  I_ONE    = (MAP_WIDTH + 1)'(1);
    localparam logic [MAP_HEIGHT:0] J_ONE    = (MAP_HEIGHT + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_BOUND, S_CHECK, S_EMIT, S_NEXT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] node_g_q, node_g_d;
    logic [MAP_WIDTH-1:0]  node_i_q, node_i_d;
    logic [MAP_HEIGHT-1:0] node_j_q, node_j_d;
    logic [MAP_WIDTH-1:0]  goal_i_q, goal_i_d;
    logic [MAP_HEIGHT-1:0] goal_j_q, goal_j_d;
    logic [2:0]            dir_q, dir_d;
    logic [MAP_WIDTH-1:0]  cand_i_q, cand_i_d;
    logic [MAP_HEIGHT-1:0] cand_j_q, cand_j_d;
    logic                  map_rd_q, map_rd_d;
    logic [DATA_WIDTH-1:0] node_f_q, node_f_d;
    logic [MAP_WIDTH-1:0]  out_i_q, out_i_d;
    logic [MAP_HEIGHT-1:0] out_j_q, out_j_d;
    logic [3:0]            count_q, count_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;

    logic [MAP_WIDTH:0]    cand_i_ext;
    logic [MAP_HEIGHT:0]   cand_j_ext;
    logic                  cand_ok;
    logic [MAP_WIDTH-1:0]  dist_i;
    logic [MAP_HEIGHT-1:0] dist_j;
    logic [H_W-1:0]        h_cost;
    logic [F_W-1:0]        f_wide;
    logic [DATA_WIDTH-1:0] f_sat;

    always_comb begin
        state_d  = state_q;
        node_g_d = node_g_q;
        node_i_d = node_i_q;
        node_j_d = node_j_q;
        goal_i_d = goal_i_q;
        goal_j_d = goal_j_q;
        dir_d    = dir_q;
        node_f_d = node_f_q;
        out_i_d  = out_i_q;
        out_j_d  = out_j_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: if (bus.i_start) begin
                node_g_d = bus.i_node_g;
                node_i_d = bus.i_node_i;
                node_j_d = bus.i_node_j;
                goal_i_d = bus.i_goal_i;
                goal_j_d = bus.i_goal_j;
                dir_d    = 3'd0;
                count_d  = 4'd0;
                state_d  = S_BOUND;
            end
            S_BOUND: state_d = map_rd_q ? S_CHECK : S_NEXT;
            S_CHECK: if (bus.i_map_blocked) begin
                state_d = S_NEXT;
            end else begin
                node_f_d = f_sat;
                out_i_d  = cand_i_q;
                out_j_d  = cand_j_q;
                state_d  = S_EMIT;
            end
            S_EMIT: if (!bus.i_full) begin
                count_d = count_q + 4'd1;
                state_d = S_NEXT;
            end
            S_NEXT: if (dir_q == LAST_DIR) begin
                state_d = S_DONE;
            end else begin
                dir_d   = dir_q + 3'd1;
                state_d = S_BOUND;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The lookup is launched from the candidate the FSM is about to enter BOUND with,
    // so o_map_rd is a register that is high exactly during the BOUND cycle.
    always_comb begin
        cand_i_ext = {1'b0, node_i_d};
        cand_j_ext = {1'b0, node_j_d};
        case (dir_d)
            3'd0: cand_i_ext = cand_i_ext + I_ONE;
            3'd1: cand_i_ext = cand_i_ext - I_ONE;
            3'd2: cand_j_ext = cand_j_ext + J_ONE;
            3'd3: cand_j_ext = cand_j_ext - J_ONE;
`ifdef OPEN_LIST_EXPANDER_DIAGONAL_EN
            3'd4: begin cand_i_ext = cand_i_ext + I_ONE; cand_j_ext = cand_j_ext + J_ONE; end
            3'd5: begin cand_i_ext = cand_i_ext + I_ONE; cand_j_ext = cand_j_ext - J_ONE; end
            3'd6: begin cand_i_ext = cand_i_ext - I_ONE; cand_j_ext = cand_j_ext + J_ONE; end
            3'd7: begin cand_i_ext = cand_i_ext - I_ONE; cand_j_ext = cand_j_ext - J_ONE; end
`endif
            default: ;
        endcase
        cand_ok  = (cand_i_ext <= I_MAX) && (cand_j_ext <= J_MAX);
        cand_i_d = cand_i_q;
        cand_j_d = cand_j_q;
        map_rd_d = 1'b0;
        if (state_d == S_BOUND) begin
            cand_i_d = cand_i_ext[MAP_WIDTH-1:0];
            cand_j_d = cand_j_ext[MAP_HEIGHT-1:0];
            map_rd_d = cand_ok;
        end
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // f = g + 1 + h with two guard bits so any carry saturates instead of wrapping.
    always_comb begin
        dist_i = (goal_i_q >= cand_i_q) ? (goal_i_q - cand_i_q) : (cand_i_q - goal_i_q);
        dist_j = (goal_j_q >= cand_j_q) ? (goal_j_q - cand_j_q) : (cand_j_q - goal_j_q);
`ifdef OPEN_LIST_EXPANDER_DIAGONAL_EN
        h_cost = (H_W'(dist_i) >= H_W'(dist_j)) ? H_W'(dist_i) : H_W'(dist_j);
`else
        h_cost = H_W'(dist_i) + H_W'(dist_j);
`endif
        f_wide = {2'b00, node_g_q} + F_W'(1) + F_W'(h_cost);
        f_sat  = (|f_wide[F_W-1:DATA_WIDTH]) ? '1 : f_wide[DATA_WIDTH-1:0];
    end

    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn) begin
            state_q  <= S_IDLE;
            node_g_q <= '0;
            node_i_q <= '0;
            node_j_q <= '0;
            goal_i_q <= '0;
            goal_j_q <= '0;
            dir_q    <= '0;
            cand_i_q <= '0;
            cand_j_q <= '0;
            map_rd_q <= 1'b0;
            node_f_q <= '0;
            out_i_q  <= '0;
            out_j_q  <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            node_g_q <= node_g_d;
            node_i_q <= node_i_d;
            node_j_q <= node_j_d;
            goal_i_q <= goal_i_d;
            goal_j_q <= goal_j_d;
            dir_q    <= dir_d;
            cand_i_q <= cand_i_d;
            cand_j_q <= cand_j_d;
            map_rd_q <= map_rd_d;
            node_f_q <= node_f_d;
            out_i_q  <= out_i_d;
            out_j_q  <= out_j_d;
            count_q  <= count_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    // The write strobe follows i_full combinationally so a full queue stalls in the same cycle.
    assign bus.o_wrt    = (state_q == S_EMIT) && !bus.i_full;
    assign bus.o_ready  = ready_q;
    assign bus.o_map_rd = map_rd_q;
    assign bus.o_map_i  = cand_i_q;
    assign bus.o_map_j  = cand_j_q;
    assign bus.o_node_f = node_f_q;
    assign bus.o_node_i = out_i_q;
    assign bus.o_node_j = out_j_q;
    assign bus.o_done   = done_q;
    assign bus.o_count  = count_q;
endmodule

// File: doc/open_list_expander.md
Name: open_list_expander

Overview:
- Expansion stage for A* search, sitting directly upstream of the open-list priority queue.
- Takes one node popped from the open list (cost-so-far g plus coordinates i, j) and generates its in-bounds grid neighbours.
- Queries an external occupancy map for each candidate; discards blocked cells.
- Computes f = g + 1 + h for each free cell and writes it into the open list with the queue's write strobe and coordinate fields, stalling on queue full.

Parameters:
- DATA_WIDTH, 32, width of g and f costs
- MAP_WIDTH, 16, width of i coordinate
- MAP_HEIGHT, 16, width of j coordinate
- GRID_I, 16, number of valid i positions (0..GRID_I-1)
- GRID_J, 16, number of valid j positions (0..GRID_J-1)

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-high
- i_start  in  1  node valid; accepted only when o_ready=1
- o_ready  out  1  idle, can accept a node
- i_node_g  in  DATA_WIDTH  cost-so-far of popped node
- i_node_i  in  MAP_WIDTH  i coordinate of popped node
- i_node_j  in  MAP_HEIGHT  j coordinate of popped node
- i_goal_i  in  MAP_WIDTH  goal i; must be held stable while busy
- i_goal_j  in  MAP_HEIGHT  goal j; must be held stable while busy
- o_map_rd  out  1  occupancy lookup strobe
- o_map_i  out  MAP_WIDTH  lookup i
- o_map_j  out  MAP_HEIGHT  lookup j
- i_map_blocked  in  1  lookup result, valid exactly 1 cycle after o_map_rd
- i_full  in  1  open-list full flag
- o_wrt  out  1  open-list write strobe
- o_node_f  out  DATA_WIDTH  f cost to write
- o_node_i  out  MAP_WIDTH  neighbour i
- o_node_j  out  MAP_HEIGHT  neighbour j
- o_done  out  1  1-cycle pulse when expansion completes
- o_count  out  4  neighbours written for last node; valid with o_done, held until next i_start

Behaviour:
- Reset values:
  - all outputs 0, except o_ready=1
  - FSM in IDLE
  - internal node, goal and direction registers cleared
- Reset asserted mid-operation: FSM returns to IDLE immediately; o_wrt and o_map_rd drop in the same cycle; no partial write completes; o_count cleared.
- IDLE:
  - o_ready=1
  - i_start=1 latches g, i, j and goal; clears o_count; sets dir=0; goes to BOUND
  - i_start while o_ready=0 is ignored
- Direction order without the optional feature: 0:(i+1,j), 1:(i-1,j), 2:(i,j+1), 3:(i,j-1).
- BOUND (1 cycle):
  - candidate is out of range if i+1 > GRID_I-1, i-1 < 0 (underflow when i=0), or the same on j; decide with a width+1 compare, never by wrapping
  - out of range: go to NEXT
  - in range: assert o_map_rd for 1 cycle with o_map_i/o_map_j set to the candidate; go to CHECK
- CHECK (1 cycle):
  - sample i_map_blocked
  - blocked: go to NEXT
  - free: register f and the candidate into o_node_*; go to EMIT
- EMIT:
  - o_wrt=1 while i_full=0; the write is accepted at the same posedge; increment o_count; go to NEXT
  - if i_full=1: o_wrt=0, o_node_* held, stay in EMIT (stall, never drop)
  - o_wrt is never high for more than 1 cycle per neighbour
- NEXT:
  - if dir = last direction: go to DONE
  - else: dir+1, go to BOUND
- DONE: o_done=1 for 1 cycle; return to IDLE; o_ready=1 from the following cycle.
- Cost arithmetic:
  - h = |goal_i - cand_i| + |goal_j - cand_j| (Manhattan), computed unsigned at width+1
  - f = g + 1 + h, computed at DATA_WIDTH+2 bits, saturating to all-ones on overflow
- Latency:
  - free, in-range neighbour with no stall: 4 cycles (BOUND, CHECK, EMIT, NEXT)
  - out-of-range neighbour: 2 cycles
  - blocked neighbour: 3 cycles
  - full interior node, no stalls: 4x4 + 1 (DONE) = 17 cycles from acceptance to o_done

Optional Feature:
- Macro: OPEN_LIST_EXPANDER_DIAGONAL_EN
- Defined:
  - 8 directions: the 4 orthogonal ones above, then 4:(i+1,j+1), 5:(i+1,j-1), 6:(i-1,j+1), 7:(i-1,j-1)
  - each diagonal checks both bounds
  - step cost remains 1
  - h = max(|di|,|dj|) (Chebyshev)
  - o_count max 8
- Undefined: 4 directions, Manhattan h; diagonal logic absent.

Test Plan:
- Basic interior expansion: GRID 16x16, node g=3 at (5,5), goal (8,9), map all free -> 4 writes in order (6,5) f=10, (4,5) f=12, (5,6) f=10, (5,4) f=12; o_done 17 cycles after acceptance; o_count=4.
- Corner: node g=0 at (0,0), goal (0,0) -> writes (1,0) f=2 and (0,1) f=2 only; no o_map_rd for out-of-range candidates; o_count=2.
- Obstacle: as the basic case but i_map_blocked=1 for (6,5) -> 3 writes, (6,5) absent; o_count=3.
- Backpressure: i_full=1 for 5 cycles on entry to first EMIT -> o_wrt low, o_node_* held at (6,5) f=10; single o_wrt pulse after i_full falls; all 4 writes delivered; o_done 5 cycles later than the unstalled case.
- Saturation and busy: g=0xFFFFFFFF -> every f=0xFFFFFFFF; i_start pulses while busy are ignored (no extra writes, o_count unchanged).
- Reset mid-op: assert RSTn during the second EMIT -> o_wrt=0 in the same cycle, o_ready=1, o_count=0; the next node expands normally.
